// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch queue.
// The fetch_queue top also honours the FETCH_QUEUE_BYPASS_EN build macro.
package fetch_pkg;

    localparam int FETCH_WIDTH = 32;
    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    typedef struct packed {
        logic [FETCH_WIDTH-1:0] pc;
        logic [31:0]            instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_ptr.sv
// Wrap-bit pointer for the fetch queue; one extra MSB distinguishes full from empty.
module fetch_queue_ptr #(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   inc,
    output logic [$clog2(DEPTH):0] ptr
);

    localparam int PW = $clog2(DEPTH) + 1;

    // Natural overflow of the PW-bit register gives the modulo 2*DEPTH wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
        end else if (clr) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + PW'(1);
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// In-order instruction fetch buffer between imem and decode, flushed on redirect.
// Define FETCH_QUEUE_BYPASS_EN for a zero-latency path from fetch_* to dec_* when empty.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   fetch_valid,
    output logic                   fetch_ready,
    input  logic [WIDTH-1:0]       fetch_pc,
    input  logic [31:0]            fetch_instr,
    input  logic                   redirect,
    output logic                   dec_valid,
    input  logic                   dec_ready,
    output logic [WIDTH-1:0]       dec_pc,
    output logic [31:0]            dec_instr,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      rd_ptr;
    logic [AW:0]      wr_ptr;
    logic [AW-1:0]    rd_idx;
    logic [AW-1:0]    wr_idx;
    logic             empty;
    logic             full;
    logic             push;
    logic             pop;
    logic             rd_inc;
    logic             wr_inc;
    logic [WIDTH-1:0] pc_mem    [DEPTH];
    logic [31:0]      instr_mem [DEPTH];

    assign rd_idx      = rd_ptr[AW-1:0];
    assign wr_idx      = wr_ptr[AW-1:0];
    assign empty       = (wr_ptr == rd_ptr);
    assign full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_idx == rd_idx);
    assign count       = wr_ptr - rd_ptr;
    assign fetch_ready = !full;

    assign push = fetch_valid && fetch_ready && !redirect;
    assign pop  = dec_valid && dec_ready;

`ifdef FETCH_QUEUE_BYPASS_EN
    logic bypass;

    // A bypassed entry that decode takes immediately never touches storage.
    assign bypass = empty && fetch_valid && !redirect;
    assign wr_inc = push && !(bypass && dec_ready);
    assign rd_inc = pop && !bypass;
`else
    assign wr_inc = push;
    assign rd_inc = pop;
`endif

    fetch_queue_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .clr (redirect),
        .inc (rd_inc),
        .ptr (rd_ptr)
    );

    fetch_queue_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .clr (redirect),
        .inc (wr_inc),
        .ptr (wr_ptr)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]    <= '0;
                instr_mem[i] <= '0;
            end
        end else if (wr_inc) begin
            pc_mem[wr_idx]    <= fetch_pc;
            instr_mem[wr_idx] <= fetch_instr;
        end
    end

    // Redirect masks the head so a wrong-path instruction can never be popped.
    always_comb begin
        dec_valid = 1'b0;
        dec_pc    = '0;
        dec_instr = NOP_INSTR;
        if (!redirect) begin
            if (!empty) begin
                dec_valid = 1'b1;
                dec_pc    = pc_mem[rd_idx];
                dec_instr = instr_mem[rd_idx];
            end
`ifdef FETCH_QUEUE_BYPASS_EN
            else if (bypass) begin
                dec_valid = 1'b1;
                dec_pc    = fetch_pc;
                dec_instr = fetch_instr;
            end
`endif
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed vector table, corner sequences, random vs queue model.
// Expectations follow FETCH_QUEUE_BYPASS_EN when the bench is built with it.
module tb_fetch_queue;
    import fetch_pkg::*;

    localparam int DEPTH = 4;
    localparam int WIDTH = 32;
    localparam int CW    = $clog2(DEPTH) + 1;
`ifdef FETCH_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          fetch_valid = 1'b0;
    logic          redirect = 1'b0;
    logic          dec_ready = 1'b0;
    logic [31:0]   fetch_pc = '0;
    logic [31:0]   fetch_instr = '0;
    logic          fetch_ready;
    logic          dec_valid;
    logic [31:0]   dec_pc;
    logic [31:0]   dec_instr;
    logic [CW-1:0] count;

    int checks = 0;
    int failures = 0;

    fetch_entry_t mq[$];
    logic [31:0]  popped_pc[$];

    typedef struct {
        logic        fv;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        red;
        logic        dr;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [31:0] exp_instr;
        int          exp_count;
        logic        exp_ready;
    } vec_t;

    vec_t vecs[$];

    fetch_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .fetch_valid (fetch_valid),
        .fetch_ready (fetch_ready),
        .fetch_pc    (fetch_pc),
        .fetch_instr (fetch_instr),
        .redirect    (redirect),
        .dec_valid   (dec_valid),
        .dec_ready   (dec_ready),
        .dec_pc      (dec_pc),
        .dec_instr   (dec_instr),
        .count       (count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    function automatic vec_t mk(input logic fv, input logic [31:0] pc, input logic [31:0] instr,
                                input logic red, input logic dr, input logic ev,
                                input logic [31:0] ep, input logic [31:0] ei, input int ec,
                                input logic er);
        vec_t v;
        v.fv = fv; v.pc = pc; v.instr = instr; v.red = red; v.dr = dr;
        v.exp_valid = ev; v.exp_pc = ep; v.exp_instr = ei; v.exp_count = ec; v.exp_ready = er;
        return v;
    endfunction

    // Reference view of the combinational outputs, from the queue contents and current inputs.
    function automatic void model_out(output logic v, output logic [31:0] p,
                                      output logic [31:0] ins, output int c, output logic rdy);
        c   = mq.size();
        rdy = (mq.size() < DEPTH);
        v   = 1'b0;
        p   = '0;
        ins = NOP_INSTR;
        if (!redirect) begin
            if (mq.size() > 0) begin
                v = 1'b1; p = mq[0].pc; ins = mq[0].instr;
            end else if (BYP && fetch_valid) begin
                v = 1'b1; p = fetch_pc; ins = fetch_instr;
            end
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic fv, input logic [31:0] pc, input logic [31:0] instr,
                                 input logic red, input logic dr);
        @(negedge clk);
        fetch_valid = fv;
        fetch_pc    = pc;
        fetch_instr = instr;
        redirect    = red;
        dec_ready   = dr;
        #1;
    endtask

    task automatic checkOutput(input string tag);
        logic v, rdy;
        logic [31:0] p, ins;
        int c;
        model_out(v, p, ins, c, rdy);
        chk({tag, "_valid"}, 32'(dec_valid), 32'(v));
        chk({tag, "_ready"}, 32'(fetch_ready), 32'(rdy));
        chk({tag, "_count"}, 32'(count), 32'(c));
        if (v || c == 0) begin
            chk({tag, "_pc"}, dec_pc, p);
            chk({tag, "_instr"}, dec_instr, ins);
        end
        if (dec_valid && dec_ready) popped_pc.push_back(dec_pc);
    endtask

    task automatic advance();
        logic v, rdy;
        logic [31:0] p, ins;
        int c;
        model_out(v, p, ins, c, rdy);
        @(posedge clk);
        if (redirect) begin
            mq.delete();
        end else if (BYP && mq.size() == 0 && fetch_valid) begin
            if (!dec_ready) mq.push_back(fetch_entry_t'{pc: fetch_pc, instr: fetch_instr});
        end else begin
            if (v && dec_ready) void'(mq.pop_front());
            if (fetch_valid && rdy) mq.push_back(fetch_entry_t'{pc: fetch_pc, instr: fetch_instr});
        end
    endtask

    task automatic step(input logic fv, input logic [31:0] pc, input logic [31:0] instr,
                        input logic red, input logic dr, input string tag);
        applyStimulus(fv, pc, instr, red, dr);
        checkOutput(tag);
        advance();
    endtask

    initial begin
        logic [31:0] ia, ib, ic, ie;
        ia = 32'hAAAA0001; ib = 32'hBBBB0002; ic = 32'hCCCC0003; ie = 32'hEEEE0040;

        vecs.push_back(mk(1, 32'h0,  ia, 0, 1, BYP, 32'h0, BYP ? ia : NOP_INSTR, 0, 1));
        vecs.push_back(mk(1, 32'h4,  ib, 0, 1, 1, BYP ? 32'h4 : 32'h0, BYP ? ib : ia, BYP ? 0 : 1, 1));
        vecs.push_back(mk(1, 32'h8,  ic, 0, 1, 1, BYP ? 32'h8 : 32'h4, BYP ? ic : ib, BYP ? 0 : 1, 1));
        vecs.push_back(mk(0, 32'h0,  '0, 0, 1, !BYP, BYP ? 32'h0 : 32'h8, BYP ? NOP_INSTR : ic, BYP ? 0 : 1, 1));
        vecs.push_back(mk(0, 32'h0,  '0, 0, 0, 0, 32'h0, NOP_INSTR, 0, 1));
        vecs.push_back(mk(1, 32'h10, 32'hD0000010, 0, 0, BYP, BYP ? 32'h10 : 32'h0, BYP ? 32'hD0000010 : NOP_INSTR, 0, 1));
        vecs.push_back(mk(1, 32'h14, 32'hD0000014, 0, 0, 1, 32'h10, 32'hD0000010, 1, 1));
        vecs.push_back(mk(1, 32'h18, 32'hD0000018, 0, 0, 1, 32'h10, 32'hD0000010, 2, 1));
        vecs.push_back(mk(1, 32'h1C, 32'hD000001C, 0, 0, 1, 32'h10, 32'hD0000010, 3, 1));
        vecs.push_back(mk(1, 32'h20, 32'hD0000020, 0, 0, 1, 32'h10, 32'hD0000010, 4, 0));
        vecs.push_back(mk(1, 32'h20, 32'hD0000020, 0, 1, 1, 32'h10, 32'hD0000010, 4, 0));
        vecs.push_back(mk(1, 32'h20, 32'hD0000020, 0, 1, 1, 32'h14, 32'hD0000014, 3, 1));
        vecs.push_back(mk(0, 32'h0,  '0, 0, 0, 1, 32'h18, 32'hD0000018, 3, 1));
        vecs.push_back(mk(1, 32'h30, 32'hD0000030, 1, 1, 0, 32'h0, NOP_INSTR, 3, 1));
        vecs.push_back(mk(1, 32'h40, ie, 0, 0, BYP, BYP ? 32'h40 : 32'h0, BYP ? ie : NOP_INSTR, 0, 1));
        vecs.push_back(mk(0, 32'h0,  '0, 0, 1, 1, 32'h40, ie, 1, 1));
        vecs.push_back(mk(0, 32'h0,  '0, 0, 0, 0, 32'h0, NOP_INSTR, 0, 1));

        repeat (2) @(negedge clk);
        #1;
        chk("rst_hold_valid", 32'(dec_valid), 32'd0);
        chk("rst_hold_count", 32'(count), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_rel_valid", 32'(dec_valid), 32'd0);
        chk("rst_rel_count", 32'(count), 32'd0);
        chk("rst_rel_ready", 32'(fetch_ready), 32'd1);
        chk("rst_rel_pc", dec_pc, 32'd0);
        chk("rst_rel_instr", dec_instr, NOP_INSTR);

        for (int i = 0; i < vecs.size(); i++) begin
            string t;
            t = $sformatf("tbl%0d", i);
            applyStimulus(vecs[i].fv, vecs[i].pc, vecs[i].instr, vecs[i].red, vecs[i].dr);
            chk({t, "_valid"}, 32'(dec_valid), 32'(vecs[i].exp_valid));
            chk({t, "_count"}, 32'(count), 32'(vecs[i].exp_count));
            chk({t, "_ready"}, 32'(fetch_ready), 32'(vecs[i].exp_ready));
            if (vecs[i].exp_valid || vecs[i].exp_count == 0) begin
                chk({t, "_pc"}, dec_pc, vecs[i].exp_pc);
                chk({t, "_instr"}, dec_instr, vecs[i].exp_instr);
            end
            checkOutput({t, "_mdl"});
            advance();
        end

        // Redirect held for several cycles keeps the queue empty.
        step(1, 32'h50, 32'h11110050, 0, 0, "hold_fill");
        step(1, 32'h54, 32'h11110054, 1, 1, "hold_r0");
        step(1, 32'h58, 32'h11110058, 1, 1, "hold_r1");
        step(1, 32'h5C, 32'h1111005C, 1, 0, "hold_r2");
        step(0, 32'h0,  32'h0,        0, 0, "hold_after");

        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 1), $urandom, $urandom, ($urandom_range(0, 15) == 0),
                 $urandom_range(0, 1), "rnd");
        end

        // Wrap test: ten entries streamed with at most two in flight.
        step(0, 32'h0, 32'h0, 1, 0, "wrap_flush");
        popped_pc.delete();
        begin
            int pushed;
            logic [31:0] next_pc;
            pushed = 0;
            next_pc = 32'h0;
            for (int cyc = 0; cyc < 200 && popped_pc.size() < 10; cyc++) begin
                logic fv;
                fv = (pushed < 10) && (mq.size() < 2);
                applyStimulus(fv, next_pc, 32'hC0000000 | next_pc, 0, 1'($urandom_range(0, 1)));
                checkOutput("wrap");
                chk("wrap_cnt_le2", 32'(count <= 2), 32'd1);
                if (fv && fetch_ready) begin
                    pushed++;
                    next_pc += 32'h4;
                end
                advance();
            end
        end
        chk("wrap_popcount", popped_pc.size(), 32'd10);
        for (int i = 0; i < popped_pc.size(); i++)
            chk($sformatf("wrap_pop%0d", i), popped_pc[i], 32'(i * 4));

        // Async reset between edges drops everything immediately.
        step(1, 32'h60, 32'h22220060, 0, 0, "mid_f0");
        step(1, 32'h64, 32'h22220064, 0, 0, "mid_f1");
        step(1, 32'h68, 32'h22220068, 0, 0, "mid_f2");
        @(negedge clk);
        fetch_valid = 1'b0;
        dec_ready   = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_valid", 32'(dec_valid), 32'd0);
        chk("midrst_count", 32'(count), 32'd0);
        chk("midrst_ready", 32'(fetch_ready), 32'd1);
        chk("midrst_pc", dec_pc, 32'd0);
        mq.delete();
        @(negedge clk);
        rst = 1'b1;
        step(1, 32'h70, 32'h33330070, 0, 1, "post_rst_push");
        step(0, 32'h0,  32'h0,        0, 1, "post_rst_next");
        step(0, 32'h0,  32'h0,        0, 0, "post_rst_idle");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
